// File: rtl/chg_entry_queue.sv
// Change-record FIFO feeding the Y-integration core, with list terminator detection.
// Optional SYM_EXPAND_EN: off-diagonal records are presented twice (as stored, then row/col swapped).
module chg_entry_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_row,
    input  logic [15:0] in_col,
    input  logic [23:0] in_real,
    input  logic [23:0] in_img,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_row,
    output logic [15:0] out_col,
    output logic [23:0] out_real,
    output logic [23:0] out_img,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        list_done,
    output logic [15:0] entry_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [79:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          list_end_q, list_end_d;
    logic [15:0]   entry_cnt_q, entry_cnt_d;

    logic [79:0] head;
    logic [15:0] head_row, head_col;
    logic        is_term, in_hs, push, pop, deq, mirror;

    assign head     = mem[rd_ptr_q];
    assign head_row = head[79:64];
    assign head_col = head[63:48];

    assign is_term = (in_row == 16'hFFFF) && (in_col == 16'hFFFF);
    assign in_hs   = in_valid && in_ready;
    assign push    = in_hs && !is_term;
    assign pop     = out_valid && out_ready;

`ifdef SYM_EXPAND_EN
    typedef enum logic {ORIG, MIRROR} state_e;
    state_e state_q;

    assign mirror = (state_q == MIRROR);
    // Off-diagonal heads stay put for one extra handshake to emit the transposed copy.
    assign deq    = pop && (mirror || (head_row == head_col));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ORIG;
        end else if (pop) begin
            state_q <= (!mirror && (head_row != head_col)) ? MIRROR : ORIG;
        end
    end
`else
    assign mirror = 1'b0;
    assign deq    = pop;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        list_end_d  = list_end_q;
        entry_cnt_d = entry_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (in_hs && is_term) list_end_d = 1'b1;
        if (pop && (entry_cnt_q != 16'hFFFF)) entry_cnt_d = entry_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            list_end_q  <= 1'b0;
            entry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            list_end_q  <= list_end_d;
            entry_cnt_q <= entry_cnt_d;
        end
    end

    // Storage needs no reset; contents are only observed while out_valid is high.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= {in_row, in_col, in_real, in_img};
    end

    assign in_ready  = !list_end_q && (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    // Count clears asynchronously, so gating on out_valid forces zero data during reset.
    assign out_row   = !out_valid ? 16'd0 : (mirror ? head_col : head_row);
    assign out_col   = !out_valid ? 16'd0 : (mirror ? head_row : head_col);
    assign out_real  = !out_valid ? 24'd0 : head[47:24];
    assign out_img   = !out_valid ? 24'd0 : head[23:0];
    assign list_done = list_end_q && (count_q == '0) && !mirror;
    assign entry_cnt = entry_cnt_q;

endmodule
